sd_resp_loader: RTL and testbench

SD_RESP_LOADER -- requirements
Module: sd_resp_loader

---
 rtl/sd_resp_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_sd_resp_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_resp_loader.sv
// SD command-response receiver: deserialises a 48- or 136-bit CMD response,
// checks framing, index and CRC7, then issues one write to the card register bank.
module sd_resp_loader #(
   parameter int NCR_MAX = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         bit_en,
   input  logic         cmd_in,
   input  logic         rx_start,
   input  logic [2:0]   resp_type,
   input  logic [5:0]   cmd_index,
   output logic         cid_en,
   output logic         csd_en,
   output logic         ocr_en,
   output logic         rca_en,
   output logic         stat_en,
   output logic [127:0] reg_data,
   output logic [31:0]  ocr_data,
   output logic [15:0]  rca_data,
   output logic [63:0]  stat_data,
   output logic         busy,
   output logic         done,
   output logic         crc_err,
   output logic         idx_err,
   output logic         frame_err,
   output logic         timeout
);

   localparam int NCR_W = $clog2(NCR_MAX + 1);
   localparam logic [NCR_W-1:0] NCR_LAST = NCR_W'(NCR_MAX - 1);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_WAIT_START = 3'd1;
   localparam logic [2:0] S_SHIFT      = 3'd2;
   localparam logic [2:0] S_CHECK      = 3'd3;
   localparam logic [2:0] S_WRITE      = 3'd4;

   localparam logic [2:0] RT_NONE = 3'd0;
   localparam logic [2:0] RT_R1   = 3'd1;
   localparam logic [2:0] RT_R2   = 3'd2;
   localparam logic [2:0] RT_R3   = 3'd3;
   localparam logic [2:0] RT_R6   = 3'd6;
   localparam logic [2:0] RT_R7   = 3'd7;

   logic [2:0]       state;
   logic [2:0]       rtype_q;
   logic [5:0]       idx_q;
   logic [135:0]     frame;
   logic [7:0]       bit_cnt;
   logic [NCR_W-1:0] ncr_cnt;
   logic [6:0]       crc;

   logic             is_r2;
   logic [7:0]       last_idx;
   logic             crc_take;
   logic             frame_bad;
   logic             idx_bad;
   logic             crc_bad;
   logic             any_bad;
   logic [63:0]      stat_word;

   // One serial step of CRC7, generator x^7 + x^3 + 1.
   function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
      logic fb;
      fb = c[6] ^ b;
      return {c[5:3], c[2] ^ fb, c[1:0], fb};
   endfunction

   // bit_cnt is the number of frame bits already received, i.e. the arrival
   // index of the next bit; frame bit N arrives at index (length-1-N).
   assign is_r2    = (rtype_q == RT_R2);
   assign last_idx = is_r2 ? 8'd135 : 8'd47;
   assign crc_take = is_r2 ? ((bit_cnt >= 8'd8) && (bit_cnt <= 8'd127))
                           : (bit_cnt <= 8'd39);

   // NOTE: every output of a combinational block gets a default at the top,
   // so no path through the case statement can leave it unassigned (latch).
   always_comb begin
      frame_bad = 1'b0;
      idx_bad   = 1'b0;
      crc_bad   = 1'b0;
      if (is_r2)
         frame_bad = frame[135] | frame[134] | (frame[133:128] != 6'h3F) | ~frame[0];
      else
         frame_bad = frame[46] | ~frame[0];
      case (rtype_q)
         RT_R1, RT_R6, RT_R7: idx_bad = (frame[45:40] != idx_q);
         RT_R3:               idx_bad = (frame[45:40] != 6'h3F);
         default:             idx_bad = 1'b0;
      endcase
      crc_bad = (rtype_q != RT_R3) && (crc != frame[7:1]);
   end

   assign any_bad   = frame_bad | idx_bad | crc_bad;
   assign stat_word = (rtype_q == RT_R6) ? {26'd0, frame[45:40], 16'd0, frame[23:8]}
                                         : {26'd0, frame[45:40], frame[39:8]};

   // NOTE: all state and registered outputs use non-blocking assignments so
   // every register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         rtype_q   <= RT_NONE;
         idx_q     <= 6'd0;
         frame     <= '0;
         bit_cnt   <= 8'd0;
         ncr_cnt   <= '0;
         crc       <= 7'd0;
         cid_en    <= 1'b0;
         csd_en    <= 1'b0;
         ocr_en    <= 1'b0;
         rca_en    <= 1'b0;
         stat_en   <= 1'b0;
         reg_data  <= '0;
         ocr_data  <= '0;
         rca_data  <= '0;
         stat_data <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         crc_err   <= 1'b0;
         idx_err   <= 1'b0;
         frame_err <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         done    <= 1'b0;
         cid_en  <= 1'b0;
         csd_en  <= 1'b0;
         ocr_en  <= 1'b0;
         rca_en  <= 1'b0;
         stat_en <= 1'b0;

         case (state)
            S_IDLE: begin
               if (rx_start) begin
                  rtype_q   <= resp_type;
                  idx_q     <= cmd_index;
                  frame     <= '0;
                  bit_cnt   <= 8'd0;
                  ncr_cnt   <= '0;
                  crc       <= 7'd0;
                  crc_err   <= 1'b0;
                  idx_err   <= 1'b0;
                  frame_err <= 1'b0;
                  timeout   <= 1'b0;
                  if (resp_type == RT_NONE) begin
                     done <= 1'b1;
                  end else begin
                     busy  <= 1'b1;
                     state <= S_WAIT_START;
                  end
               end
            end

            S_WAIT_START: begin
               if (bit_en) begin
                  if (!cmd_in) begin
                     // The start bit is a zero; with a zero seed it leaves the CRC unchanged.
                     frame   <= {frame[134:0], 1'b0};
                     bit_cnt <= 8'd1;
                     state   <= S_SHIFT;
                  end else if (ncr_cnt == NCR_LAST) begin
                     timeout <= 1'b1;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     state   <= S_IDLE;
                  end else begin
                     ncr_cnt <= ncr_cnt + 1'b1;
                  end
               end
            end

            S_SHIFT: begin
               if (bit_en) begin
                  frame   <= {frame[134:0], cmd_in};
                  bit_cnt <= bit_cnt + 8'd1;
                  if (crc_take)
                     crc <= crc7_next(crc, cmd_in);
                  if (bit_cnt == last_idx)
                     state <= S_CHECK;
               end
            end

            S_CHECK: begin
               done <= 1'b1;
               if (any_bad) begin
                  crc_err   <= crc_bad;
                  idx_err   <= idx_bad;
                  frame_err <= frame_bad;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  state <= S_WRITE;
                  case (rtype_q)
                     RT_R1, RT_R7: begin
                        stat_en   <= 1'b1;
                        stat_data <= stat_word;
                     end
                     RT_R2: begin
                        if (idx_q == 6'd9)
                           csd_en <= 1'b1;
                        else
                           cid_en <= 1'b1;
                        reg_data <= frame[127:0];
                     end
                     RT_R3: begin
                        ocr_en   <= 1'b1;
                        ocr_data <= frame[39:8];
                     end
                     RT_R6: begin
                        rca_en    <= 1'b1;
                        stat_en   <= 1'b1;
                        rca_data  <= frame[39:24];
                        stat_data <= stat_word;
                     end
                     default: ;
                  endcase
               end
            end

            S_WRITE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_resp_loader.sv
// Self-checking bench for sd_resp_loader: directed vector table, hand-built
// corner sequences, and random responses scored against a CRC-by-division model.
module tb_sd_resp_loader;

   logic         clk;
   logic         reset;
   logic         bit_en;
   logic         cmd_in;
   logic         rx_start;
   logic [2:0]   resp_type;
   logic [5:0]   cmd_index;
   logic         cid_en, csd_en, ocr_en, rca_en, stat_en;
   logic [127:0] reg_data;
   logic [31:0]  ocr_data;
   logic [15:0]  rca_data;
   logic [63:0]  stat_data;
   logic         busy, done;
   logic         crc_err, idx_err, frame_err, timeout;

   sd_resp_loader #(.NCR_MAX(64)) dut (
      .clk(clk), .reset(reset), .bit_en(bit_en), .cmd_in(cmd_in),
      .rx_start(rx_start), .resp_type(resp_type), .cmd_index(cmd_index),
      .cid_en(cid_en), .csd_en(csd_en), .ocr_en(ocr_en), .rca_en(rca_en),
      .stat_en(stat_en), .reg_data(reg_data), .ocr_data(ocr_data),
      .rca_data(rca_data), .stat_data(stat_data), .busy(busy), .done(done),
      .crc_err(crc_err), .idx_err(idx_err), .frame_err(frame_err),
      .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Enables packed as {cid, csd, ocr, rca, stat}; flags as {crc, idx, frame, timeout}.
   typedef struct {
      logic [4:0]   en;
      logic [3:0]   fl;
      logic [127:0] rg;
      logic [31:0]  ocr;
      logic [15:0]  rca;
      logic [63:0]  st;
   } exp_t;

   typedef struct {
      logic [2:0]   rt;
      logic [5:0]   idx;
      logic [135:0] frame;
      int           period;
      int           ncr;
      bit           poke;
      exp_t         e;
   } vec_t;

   vec_t vq[$];

   int n_pass  = 0;
   int n_total = 0;

   int           n_done;
   int           n_en_tot;
   logic [4:0]   en_s;
   logic [3:0]   fl_s;
   logic [127:0] reg_s;
   logic [31:0]  ocr_s;
   logic [15:0]  rca_s;
   logic [63:0]  stat_s;
   logic         busy_s;

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (long division).
   function automatic logic [6:0] crc7_div(input logic [119:0] msg, input int nbits);
      logic [126:0] r;
      r = {msg, 7'd0};
      for (int i = nbits + 6; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   function automatic exp_t model(input logic [2:0] rt, input logic [5:0] idx, input logic [135:0] f);
      exp_t e;
      bit fe, ie, ce;
      logic [6:0] c;
      e.en = '0; e.fl = '0; e.rg = '0; e.ocr = '0; e.rca = '0; e.st = '0;
      if (rt == 3'd0) return e;
      if (rt == 3'd2) begin
         fe = f[134] || (f[133:128] != 6'h3F) || !f[0];
         c  = crc7_div(f[127:8], 120);
      end else begin
         fe = f[46] || !f[0];
         c  = crc7_div(120'(f[47:8]), 40);
      end
      if (rt == 3'd1 || rt == 3'd6 || rt == 3'd7) ie = (f[45:40] != idx);
      else if (rt == 3'd3)                        ie = (f[45:40] != 6'h3F);
      else                                        ie = 1'b0;
      ce = (rt != 3'd3) && (c != f[7:1]);
      e.fl = {ce, ie, fe, 1'b0};
      if (fe || ie || ce) return e;
      case (rt)
         3'd1, 3'd7: begin e.en = 5'b00001; e.st = {26'd0, f[45:40], f[39:8]}; end
         3'd2:       begin e.en = (idx == 6'd9) ? 5'b01000 : 5'b10000; e.rg = f[127:0]; end
         3'd3:       begin e.en = 5'b00100; e.ocr = f[39:8]; end
         3'd6:       begin e.en = 5'b00011; e.rca = f[39:24];
                           e.st = {26'd0, f[45:40], 16'd0, f[23:8]}; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic clear_mon();
      n_done = 0; n_en_tot = 0; en_s = '0; fl_s = '0;
   endtask

   // One clock: drive just after the rising edge, observe on the falling edge.
   task automatic cycle(input logic be, input logic ci, input logic rs);
      @(posedge clk);
      #1;
      bit_en = be; cmd_in = ci; rx_start = rs;
      @(negedge clk);
      n_en_tot += $countones({cid_en, csd_en, ocr_en, rca_en, stat_en});
      if (done) begin
         n_done++;
         en_s   = {cid_en, csd_en, ocr_en, rca_en, stat_en};
         fl_s   = {crc_err, idx_err, frame_err, timeout};
         reg_s  = reg_data; ocr_s = ocr_data; rca_s = rca_data; stat_s = stat_data;
      end
   endtask

   task automatic send_bit(input logic b, input int period);
      for (int p = 0; p < period - 1; p++) cycle(1'b0, b, 1'b0);
      cycle(1'b1, b, 1'b0);
   endtask

   task automatic run_txn(input logic [2:0] rt, input logic [5:0] idx, input logic [135:0] f,
                          input int period, input int ncr, input bit poke);
      int len;
      clear_mon();
      resp_type = rt; cmd_index = idx;
      cycle(1'b0, 1'b1, 1'b1);
      if (rt != 3'd0) begin
         len = (rt == 3'd2) ? 136 : 48;
         for (int k = 0; k < ncr; k++) send_bit(1'b1, period);
         for (int i = len - 1; i >= 0; i--) begin
            send_bit(f[i], period);
            if (poke && i == len - 10) begin
               resp_type = 3'd0;
               cycle(1'b0, 1'b1, 1'b1);
               resp_type = rt;
            end
         end
      end
      for (int b = 0; b < 8 && n_done == 0; b++) cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      busy_s = busy;
   endtask

   task automatic check_txn(input string tag, input exp_t e);
      check({tag, " done_count"}, n_done, 1);
      check({tag, " enables"}, en_s, e.en);
      check({tag, " enable_pulses"}, n_en_tot, $countones(e.en));
      check({tag, " flags"}, fl_s, e.fl);
      if (e.en[4] | e.en[3]) check({tag, " reg_data"}, reg_s, e.rg);
      if (e.en[2]) check({tag, " ocr_data"}, ocr_s, e.ocr);
      if (e.en[1]) check({tag, " rca_data"}, rca_s, e.rca);
      if (e.en[0]) check({tag, " stat_data"}, stat_s, e.st);
      check({tag, " busy_after"}, busy_s, 0);
   endtask

   task automatic add_vec(input logic [2:0] rt, input logic [5:0] idx, input logic [135:0] f,
                          input int period, input int ncr, input bit poke,
                          input logic [4:0] en, input logic [3:0] fl, input logic [127:0] rg,
                          input logic [31:0] ocr, input logic [15:0] rca, input logic [63:0] st);
      vec_t v;
      v.rt = rt; v.idx = idx; v.frame = f; v.period = period; v.ncr = ncr; v.poke = poke;
      v.e.en = en; v.e.fl = fl; v.e.rg = rg; v.e.ocr = ocr; v.e.rca = rca; v.e.st = st;
      vq.push_back(v);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [119:0] r2_body;
      logic [135:0] f_r2, f_r6, f_r7;
      logic [39:0]  r6_hdr;
      logic [2:0]   rt_pool [6];
      logic [2:0]   rt;
      logic [5:0]   idx, fidx;
      logic [135:0] f;
      logic [39:0]  h40;
      logic [6:0]   c;
      logic [7:0]   h8;

      reset = 1'b1; bit_en = 1'b0; cmd_in = 1'b1; rx_start = 1'b0;
      resp_type = 3'd0; cmd_index = 6'd0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {cid_en, csd_en, ocr_en, rca_en, stat_en, reg_data, ocr_data, rca_data,
             stat_data, busy, done, crc_err, idx_err, frame_err, timeout}, 0);
      @(posedge clk); #1 reset = 1'b0;

      f_r7    = 136'h08_000001AA_13;
      r2_body = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C, 24'h4B5A69};
      f_r2    = {8'h3F, r2_body, crc7_div(r2_body, 120), 1'b1};
      r6_hdr  = {8'h03, 32'h1234_0500};
      f_r6    = {88'd0, r6_hdr, crc7_div(120'(r6_hdr), 40), 1'b1};

      add_vec(3'd7, 6'd8,  f_r7,                    1, 2, 0, 5'b00001, 4'b0000, '0, '0, '0, 64'h0000_0008_0000_01AA);
      add_vec(3'd3, 6'd41, 136'h3F_80FF8000_FF,     1, 0, 0, 5'b00100, 4'b0000, '0, 32'h80FF8000, '0, '0);
      add_vec(3'd7, 6'd8,  136'h08_000001AA_15,     1, 3, 0, 5'b00000, 4'b1000, '0, '0, '0, '0);
      add_vec(3'd2, 6'd9,  f_r2,                    4, 1, 0, 5'b01000, 4'b0000, f_r2[127:0], '0, '0, '0);
      add_vec(3'd2, 6'd2,  f_r2,                    2, 5, 0, 5'b10000, 4'b0000, f_r2[127:0], '0, '0, '0);
      add_vec(3'd6, 6'd3,  f_r6,                    1, 0, 1, 5'b00011, 4'b0000, '0, '0, 16'h1234, 64'h0000_0003_0000_0500);
      add_vec(3'd1, 6'd17, f_r7,                    1, 1, 0, 5'b00000, 4'b0100, '0, '0, '0, '0);
      add_vec(3'd7, 6'd8,  136'h08_000001AA_12,     1, 0, 0, 5'b00000, 4'b0010, '0, '0, '0, '0);
      add_vec(3'd0, 6'd5,  '0,                      1, 0, 0, 5'b00000, 4'b0000, '0, '0, '0, '0);
      add_vec(3'd3, 6'd0,  136'h3E_80FF8000_FF,     1, 0, 0, 5'b00000, 4'b0100, '0, '0, '0, '0);
      add_vec(3'd1, 6'd8,  f_r7,                    3, 7, 0, 5'b00001, 4'b0000, '0, '0, '0, 64'h0000_0008_0000_01AA);

      foreach (vq[i]) begin
         run_txn(vq[i].rt, vq[i].idx, vq[i].frame, vq[i].period, vq[i].ncr, vq[i].poke);
         check_txn($sformatf("vec%0d", i), vq[i].e);
      end

      // Timeout: 63 idle bit-times are tolerated, the 64th ends the transfer.
      clear_mon();
      resp_type = 3'd1; cmd_index = 6'd13;
      cycle(1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 64; k++) send_bit(1'b1, 1);
      check("timeout_not_early", n_done, 0);
      cycle(1'b0, 1'b1, 1'b0);
      check("timeout_done", n_done, 1);
      check("timeout_flags", fl_s, 4'b0001);
      check("timeout_no_enables", n_en_tot, 0);
      check("timeout_busy", busy, 0);

      // Reset in the middle of an R1 frame, away from any clock edge.
      clear_mon();
      resp_type = 3'd1; cmd_index = 6'd8;
      cycle(1'b0, 1'b1, 1'b1);
      for (int i = 47; i >= 28; i--) send_bit(f_r7[i], 1);
      check("midframe_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      check("midframe_reset_outputs",
            {cid_en, csd_en, ocr_en, rca_en, stat_en, reg_data, ocr_data, rca_data,
             stat_data, busy, done, crc_err, idx_err, frame_err, timeout}, 0);
      @(posedge clk); #1 reset = 1'b0;
      run_txn(3'd1, 6'd8, f_r7, 1, 2, 0);
      check_txn("after_reset", model(3'd1, 6'd8, f_r7));

      // Random responses against the reference model.
      rt_pool = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
      for (int n = 0; n < 40; n++) begin
         rt  = rt_pool[$urandom_range(0, 5)];
         idx = 6'($urandom_range(0, 63));
         if (rt == 3'd2) begin
            r2_body = {$urandom(), $urandom(), $urandom(), 24'($urandom())};
            h8 = 8'h3F;
            if ($urandom_range(0, 7) == 0) h8 = 8'h3E;
            if ($urandom_range(0, 7) == 0) h8 = 8'h7F;
            c = crc7_div(r2_body, 120);
            if ($urandom_range(0, 7) == 0) c = c ^ 7'h11;
            f = {h8, r2_body, c, ($urandom_range(0, 7) != 0)};
         end else begin
            fidx = (rt == 3'd3) ? 6'h3F : idx;
            if ($urandom_range(0, 3) == 0) fidx = 6'($urandom());
            h40 = {1'b0, ($urandom_range(0, 7) == 0), fidx, 32'($urandom())};
            c = (rt == 3'd3) ? 7'($urandom()) : crc7_div(120'(h40), 40);
            if ($urandom_range(0, 7) == 0) c = c ^ 7'h40;
            f = {88'd0, h40, c, ($urandom_range(0, 7) != 0)};
         end
         run_txn(rt, idx, f, $urandom_range(1, 3), $urandom_range(0, 10), 0);
         check_txn($sformatf("rand%0d_rt%0d", n, rt), model(rt, idx, f));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
